// File: rtl/lsu_byte_master.sv
// lsu_byte_master
//   Load/store unit that turns one RV32I load or store (byte, half, word,
//   unsigned byte, unsigned half) into back-to-back single-byte memory beats.
//   Loads are reassembled little-endian, then sign or zero extended, and
//   returned with a one-cycle response pulse.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   req_valid / req_ready  : request handshake (ready only while idle)
//   req_we, req_func3      : store flag and access size/sign encoding
//   req_addr, req_wdata    : base byte address (may be misaligned), store data
//   rsp_valid              : one-cycle completion pulse
//   rsp_rdata, rsp_err     : extended load data / illegal-request flag (held)
//   mem_en, mem_we         : byte beat strobe and write qualifier
//   mem_addr, mem_wdata    : beat byte address and write byte
//   mem_rdata              : read byte, valid the cycle after a read beat
module lsu_byte_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          func3_q, func3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          k_q, k_d;
  logic [31:0]         asm_q, asm_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept;
  logic                req_legal;
  logic [1:0]          last_idx;
  logic [1:0]          k_next;
  logic [31:0]         asm_fin;
  logic [31:0]         ext_data;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Outputs are forced low combinationally while reset is held, so a beat
  // in flight when reset arrives never reaches the memory.
  assign mem_en    = mem_en_q && !reset;
  assign mem_we    = mem_we_q && !reset;
  assign mem_addr  = reset ? '0 : mem_addr_q;
  assign mem_wdata = reset ? '0 : mem_wdata_q;
  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_rdata = reset ? '0 : rsp_rdata_q;
  assign rsp_err   = rsp_err_q && !reset;

  // Unsigned encodings exist only for loads.
  always_comb begin
    case (req_func3)
      3'd0, 3'd1, 3'd2: req_legal = 1'b1;
      3'd4, 3'd5:       req_legal = !req_we;
      default:          req_legal = 1'b0;
    endcase
  end

  // Index of the final beat of the latched request.
  always_comb begin
    case (func3_q)
      3'd0, 3'd4: last_idx = 2'd0;
      3'd1, 3'd5: last_idx = 2'd1;
      default:    last_idx = 2'd3;
    endcase
  end

  // Final assembly merges the byte returned by the last beat, then extends.
  always_comb begin
    asm_fin = asm_q;
    asm_fin[{last_idx, 3'b000} +: 8] = mem_rdata;
    case (func3_q)
      3'd0:    ext_data = {{24{asm_fin[7]}}, asm_fin[7:0]};
      3'd1:    ext_data = {{16{asm_fin[15]}}, asm_fin[15:0]};
      3'd2:    ext_data = asm_fin;
      3'd4:    ext_data = {24'd0, asm_fin[7:0]};
      3'd5:    ext_data = {16'd0, asm_fin[15:0]};
      default: ext_data = 32'd0;
    endcase
  end

  // Next-state logic. Memory-side outputs are registered, so each state
  // prepares the beat that will be presented in the following cycle.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    asm_d       = asm_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rsp_valid_d = 1'b0;
    k_next      = k_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          k_d     = 2'd0;
          asm_d   = 32'd0;
          if (!req_legal) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = ST_XFER;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata[7:0];
          end
        end
      end

      ST_XFER: begin
        // k_q is the beat on the bus now; mem_rdata belongs to beat k_q-1.
        if (!we_q && (k_q != 2'd0)) begin
          asm_d[{k_q - 2'd1, 3'b000} +: 8] = mem_rdata;
        end
        if (k_q == last_idx) begin
          if (we_q) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          k_d         = k_next;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_W'(k_next);
          mem_wdata_d = wdata_q[{k_next, 3'b000} +: 8];
        end
      end

      ST_DRAIN: begin
        asm_d       = asm_fin;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ext_data;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      func3_q     <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      k_q         <= 2'd0;
      asm_q       <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      asm_q       <= asm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master
//   Directed bench for lsu_byte_master: a 256-byte memory (indexed by the low
//   address byte) answers beats, and each test task checks beat sequencing,
//   response timing and load extension against hand-computed values.
module tb_lsu_byte_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'd0;
  logic [7:0]  poke_data = 8'd0;
  int          beat_cnt = 0;
  int          rsp_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  lsu_byte_master #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous byte memory: read data appears the cycle after a read beat.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_en) begin
      beat_cnt <= beat_cnt + 1;
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // Presents a request at a negedge while idle; returns just after edge T.
  task automatic issue_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we} !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000",
               {req_ready, rsp_valid, rsp_err, mem_en, mem_we});
    end
    n_cmp++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 72'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h, expected 0", {rsp_rdata, mem_addr, mem_wdata});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, mem_en} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL post_reset: got %b, expected 100", {req_ready, rsp_valid, mem_en});
    end
  endtask

  task automatic test_store_word;
    logic [31:0] wd;
    logic [41:0] got, exp;
    wd = 32'hDEADBEEF;
    issue_req(1'b1, 3'd2, 32'h10, wd);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {mem_en, mem_we, mem_addr, mem_wdata};
      exp = {1'b1, 1'b1, 32'h10 + i, wd[8*i +: 8]};
      n_cmp++;
      if (got !== exp || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL store_beat%0d: got %h v%b r%b, expected %h v0 r0",
                 i, got, rsp_valid, req_ready, exp);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_en} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL store_rsp: got v%b e%b d%h m%b, expected v1 e0 d0 m0",
               rsp_valid, rsp_err, rsp_rdata, mem_en);
    end
    n_cmp++;
    if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL store_mem: got %h, expected deadbeef",
               {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]});
    end
  endtask

  task automatic test_load_half;
    logic [2:0]  f3s  [2];
    logic [31:0] exps [2];
    f3s  = '{3'd1, 3'd5};
    exps = '{32'hFFFF8034, 32'h00008034};
    poke(8'h21, 8'h34);
    poke(8'h22, 8'h80);
    for (int t = 0; t < 2; t++) begin
      issue_req(1'b0, f3s[t], 32'h21, 32'd0);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h21 + i}) begin
          n_fail++;
          $display("[TB] FAIL half_beat%0d f3=%0d: got %h, expected %h", i, f3s[t],
                   {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h21 + i});
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_en, rsp_valid} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL half_drain f3=%0d: got %b, expected 00", f3s[t], {mem_en, rsp_valid});
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exps[t]}) begin
        n_fail++;
        $display("[TB] FAIL half_rsp f3=%0d: got v%b e%b d%h, expected v1 e0 d%h",
                 f3s[t], rsp_valid, rsp_err, rsp_rdata, exps[t]);
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_rdata} !== {1'b0, 1'b1, exps[t]}) begin
        n_fail++;
        $display("[TB] FAIL half_hold f3=%0d: got v%b r%b d%h, expected v0 r1 d%h",
                 f3s[t], rsp_valid, req_ready, rsp_rdata, exps[t]);
      end
    end
  endtask

  task automatic test_load_byte;
    logic [2:0]  f3s  [2];
    logic [31:0] exps [2];
    f3s  = '{3'd0, 3'd4};
    exps = '{32'hFFFFFF9C, 32'h0000009C};
    poke(8'h05, 8'h9C);
    for (int t = 0; t < 2; t++) begin
      issue_req(1'b0, f3s[t], 32'h05, 32'd0);
      @(negedge clk);
      n_cmp++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h05}) begin
        n_fail++;
        $display("[TB] FAIL byte_beat f3=%0d: got %h, expected %h", f3s[t],
                 {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h05});
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_en, rsp_valid} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL byte_drain f3=%0d: got %b, expected 00", f3s[t], {mem_en, rsp_valid});
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exps[t]}) begin
        n_fail++;
        $display("[TB] FAIL byte_rsp f3=%0d: got v%b e%b d%h, expected v1 e0 d%h",
                 f3s[t], rsp_valid, rsp_err, rsp_rdata, exps[t]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] addrs [4];
    addrs = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    poke(8'hFE, 8'h11);
    poke(8'hFF, 8'h22);
    poke(8'h00, 8'h33);
    poke(8'h01, 8'h44);
    issue_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, addrs[i]}) begin
        n_fail++;
        $display("[TB] FAIL wrap_beat%0d: got %h, expected %h", i,
                 {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, addrs[i]});
      end
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h44332211}) begin
      n_fail++;
      $display("[TB] FAIL wrap_rsp: got v%b e%b d%h, expected v1 e0 d44332211",
               rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_illegal;
    logic       wes [2];
    logic [2:0] f3s [2];
    int         b0;
    wes = '{1'b0, 1'b1};
    f3s = '{3'd3, 3'd4};
    for (int t = 0; t < 2; t++) begin
      b0 = beat_cnt;
      issue_req(wes[t], f3s[t], 32'h30, 32'h12345678);
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_err, mem_en, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
        n_fail++;
        $display("[TB] FAIL illegal_rsp we=%b f3=%0d: got v%b e%b m%b d%h, expected v1 e1 m0 d0",
                 wes[t], f3s[t], rsp_valid, rsp_err, mem_en, rsp_rdata);
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_err, mem_en} !== 4'b0110 || beat_cnt !== b0) begin
        n_fail++;
        $display("[TB] FAIL illegal_after we=%b f3=%0d: got %b beats=%0d, expected 0110 beats=0",
                 wes[t], f3s[t], {rsp_valid, req_ready, rsp_err, mem_en}, beat_cnt - b0);
      end
    end
  endtask

  task automatic test_reset_mid_store;
    int r0;
    for (int i = 0; i < 4; i++) poke(8'h40 + 8'(i), 8'h00);
    r0 = rsp_cnt;
    issue_req(1'b1, 3'd2, 32'h40, 32'h11223344);
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 8'h44}) begin
      n_fail++;
      $display("[TB] FAIL rst_beat0: got %h, expected %h",
               {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h40, 8'h44});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_en, mem_we} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL rst_gate: got %b, expected 00", {mem_en, mem_we});
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_en, req_ready, rsp_valid} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL rst_hold: got %b, expected 000", {mem_en, req_ready, rsp_valid});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_en, rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL rst_release: got %b, expected 100", {req_ready, mem_en, rsp_valid});
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} !== 32'h00000044 || rsp_cnt !== r0) begin
      n_fail++;
      $display("[TB] FAIL rst_mem: got %h rsps=%0d, expected 00000044 rsps=0",
               {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, rsp_cnt - r0);
    end
  endtask

  task automatic test_back_to_back;
    issue_req(1'b1, 3'd2, 32'h80, 32'hA1B2C3D4);
    repeat (4) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL b2b_store_rsp: got %b, expected 10", {rsp_valid, req_ready});
    end
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_func3 = 3'd2;
    req_addr  = 32'h80;
    req_wdata = 32'd0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, mem_en} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL b2b_ready: got %b, expected 100", {req_ready, rsp_valid, mem_en});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h80 + i}) begin
        n_fail++;
        $display("[TB] FAIL b2b_load_beat%0d: got %h, expected %h", i,
                 {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h80 + i});
      end
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hA1B2C3D4}) begin
      n_fail++;
      $display("[TB] FAIL b2b_load_rsp: got v%b e%b d%h, expected v1 e0 da1b2c3d4",
               rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_half();
    test_load_byte();
    test_wrap();
    test_illegal();
    test_reset_mid_store();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
